// File: rtl/llr_frame_loader.sv
// LDPC front end: rounds/saturates channel LLRs and packs them into frames.
// Two frame buffers ping-pong so one loads while the decoder holds the other.
module llr_frame_loader #(
    parameter int WIDTH      = 8,
    parameter int IN_WIDTH   = 12,
    parameter int SHIFT      = 4,
    parameter int ROW_NUMBER = 12
) (
    input  logic                        clk,
    input  logic                        xrst,
    input  logic [IN_WIDTH-1:0]         i_llr,
    input  logic                        i_llr_val,
    input  logic                        i_llr_last,
    output logic                        o_llr_rdy,
    output logic [WIDTH*ROW_NUMBER-1:0] o_data,
    output logic                        o_val,
    input  logic                        i_rdy,
    output logic                        o_err,
    output logic [7:0]                  o_err_cnt
);

    localparam int FW = WIDTH * ROW_NUMBER;
    localparam int CW = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1;
    localparam int EW = IN_WIDTH + 1;

    localparam logic signed [EW-1:0] BIAS = EW'((2 ** SHIFT) / 2);
    localparam logic signed [EW-1:0] MAXV = EW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [EW-1:0] MINV = -MAXV;
    localparam logic [CW-1:0]        LAST_SLOT = CW'(ROW_NUMBER - 1);

    typedef enum logic {
        LOAD,
        DROP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_sel_q, wr_sel_d;
    logic            rd_sel_q, rd_sel_d;
    logic [1:0]      full_q, full_d;
    logic [FW-1:0]   bank_q [2];
    logic [FW-1:0]   bank_d [2];
    logic            err_d;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] sh;
    logic [WIDTH-1:0]     word;
    logic                 accept;
    logic                 release_frame;

    // Round half-up in the wider domain, then clip symmetrically.
    assign ext = signed'({i_llr[IN_WIDTH-1], i_llr});
    assign rnd = ext + BIAS;
    assign sh  = rnd >>> SHIFT;

    always_comb begin
        if (sh > MAXV) begin
            word = MAXV[WIDTH-1:0];
        end else if (sh < MINV) begin
            word = MINV[WIDTH-1:0];
        end else begin
            word = sh[WIDTH-1:0];
        end
    end

    assign o_llr_rdy     = !xrst && (state_q == DROP || !full_q[wr_sel_q]);
    assign accept        = i_llr_val && o_llr_rdy;
    assign release_frame = o_val && i_rdy;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        full_d   = full_q;
        bank_d   = bank_q;
        err_d    = 1'b0;

        if (release_frame) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
        end

        if (accept) begin
            unique case (state_q)
                LOAD: begin
                    for (int k = 0; k < ROW_NUMBER; k++) begin
                        if (cnt_q == CW'(k)) begin
                            bank_d[wr_sel_q][k*WIDTH +: WIDTH] = word;
                        end
                    end
                    unique case (1'b1)
                        (cnt_q == LAST_SLOT && i_llr_last): begin
                            full_d[wr_sel_q] = 1'b1;
                            wr_sel_d         = !wr_sel_q;
                            cnt_d            = '0;
                        end
                        (cnt_q != LAST_SLOT && i_llr_last): begin
                            err_d = 1'b1;
                            cnt_d = '0;
                        end
                        (cnt_q == LAST_SLOT && !i_llr_last): begin
                            err_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = DROP;
                        end
                        default: begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    endcase
                end
                DROP: begin
                    if (i_llr_last) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    // Outputs come from the next-state view so a frame shows the edge it completes.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            full_q    <= '0;
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            o_val     <= 1'b0;
            o_data    <= '0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            full_q    <= full_d;
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            o_val     <= full_d[rd_sel_d];
            o_data    <= bank_d[rd_sel_d];
            o_err     <= err_d;
            if (err_d && o_err_cnt != 8'hFF) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_llr_frame_loader.sv
// Directed bench for llr_frame_loader with a frame-queue reference model.
// The model tracks held frames as a queue and checks outputs every cycle.
module tb_llr_frame_loader;

    localparam int W  = 8;
    localparam int IW = 12;
    localparam int SH = 4;
    localparam int R  = 12;
    localparam int FW = W * R;

    logic          clk;
    logic          xrst;
    logic [IW-1:0] i_llr;
    logic          i_llr_val;
    logic          i_llr_last;
    logic          o_llr_rdy;
    logic [FW-1:0] o_data;
    logic          o_val;
    logic          i_rdy;
    logic          o_err;
    logic [7:0]    o_err_cnt;

    llr_frame_loader #(
        .WIDTH(W), .IN_WIDTH(IW), .SHIFT(SH), .ROW_NUMBER(R)
    ) dut (
        .clk(clk), .xrst(xrst),
        .i_llr(i_llr), .i_llr_val(i_llr_val), .i_llr_last(i_llr_last),
        .o_llr_rdy(o_llr_rdy), .o_data(o_data), .o_val(o_val),
        .i_rdy(i_rdy), .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference conversion: floor((x + 2^(SH-1)) / 2^SH), clipped to +/-127.
    function automatic int conv(input int x);
        int t, d, q;
        d = 1 << SH;
        t = x + d / 2;
        if (t >= 0) q = t / d;
        else q = -((-t + d - 1) / d);
        if (q > 127) q = 127;
        if (q < -127) q = -127;
        return q;
    endfunction

    logic [FW-1:0] q_frames[$];
    int            cur[R];
    int            n;
    bit            drop;
    bit            m_err;
    int            m_cnt;

    always @(posedge clk or posedge xrst) begin : model
        bit rdy0, acc, rel;
        logic [FW-1:0] f;
        if (xrst) begin
            q_frames.delete();
            n = 0;
            drop = 1'b0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            rdy0 = drop || q_frames.size() < 2;
            acc = i_llr_val && rdy0;
            rel = q_frames.size() > 0 && i_rdy;
            m_err = 1'b0;
            if (rel) void'(q_frames.pop_front());
            if (acc) begin
                if (drop) begin
                    if (i_llr_last) begin
                        drop = 1'b0;
                        n = 0;
                    end
                end else begin
                    cur[n] = conv(int'(signed'(i_llr)));
                    n++;
                    if (i_llr_last) begin
                        if (n == R) begin
                            for (int k = 0; k < R; k++) f[k*W +: W] = W'(cur[k]);
                            q_frames.push_back(f);
                        end else begin
                            m_err = 1'b1;
                        end
                        n = 0;
                    end else if (n == R) begin
                        m_err = 1'b1;
                        drop = 1'b1;
                        n = 0;
                    end
                end
            end
            if (m_err && m_cnt < 255) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdy", FW'(o_llr_rdy), FW'(!xrst && (drop || q_frames.size() < 2)));
            chk("val", FW'(o_val), FW'(q_frames.size() > 0));
            chk("err", FW'(o_err), FW'(m_err));
            chk("err_cnt", FW'(o_err_cnt), FW'(m_cnt));
            if (q_frames.size() > 0) chk("data", o_data, q_frames[0]);
        end
    end

    task automatic send(input int v, input bit last);
        int w;
        w = 0;
        i_llr = IW'(v);
        i_llr_val = 1'b1;
        i_llr_last = last;
        while (!o_llr_rdy && w <= 300) begin
            @(negedge clk);
            w++;
        end
        if (w > 300) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got rdy=0 required rdy=1");
        end else begin
            @(negedge clk);
        end
        i_llr_val = 1'b0;
        i_llr_last = 1'b0;
    endtask

    task automatic send_frame(input int base, input int len, input bit with_last);
        for (int k = 0; k < len; k++) send((base + k) * 16, with_last && k == len - 1);
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 xrst = 1'b1;
        @(posedge clk);
        #2 xrst = 1'b0;
        @(negedge clk);
    endtask

    int t2v[R];
    logic [W-1:0] t2e[6];

    initial begin
        xrst = 1'b1;
        i_llr = '0;
        i_llr_val = 1'b0;
        i_llr_last = 1'b0;
        i_rdy = 1'b0;
        @(posedge clk);
        #2 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_val", FW'(o_val), FW'(0));
        chk("rst_rdy", FW'(o_llr_rdy), FW'(0));
        chk("rst_data", o_data, FW'(0));
        chk("rst_cnt", FW'(o_err_cnt), FW'(0));
        @(posedge clk);
        #2 xrst = 1'b0;
        @(negedge clk);

        // T1: word k must equal k, visible the cycle after the last sample.
        i_rdy = 1'b1;
        send_frame(0, R, 1'b1);
        chk("t1_val", FW'(o_val), FW'(1));
        for (int k = 0; k < R; k++) chk("t1_word", FW'(o_data[k*W +: W]), FW'(k));
        idle(2);

        // T2: rounding and symmetric saturation.
        t2v = '{2047, -2048, 8, 7, -8, -9, 0, 0, 0, 0, 0, 0};
        t2e = '{8'h7F, 8'h81, 8'h01, 8'h00, 8'h00, 8'hFF};
        for (int k = 0; k < R; k++) send(t2v[k], k == R - 1);
        for (int k = 0; k < 6; k++) chk("t2_word", FW'(o_data[k*W +: W]), FW'(t2e[k]));
        idle(2);

        // T3: back-pressure with both buffers full, then slow drain.
        i_rdy = 1'b0;
        send_frame(20, R, 1'b1);
        send_frame(40, R, 1'b1);
        chk("t3_rdy_low", FW'(o_llr_rdy), FW'(0));
        chk("t3_first", FW'(o_data[W-1:0]), FW'(20));
        fork
            send_frame(60, R, 1'b1);
            begin
                for (int i = 0; i < 16; i++) begin
                    i_rdy = 1'b1;
                    @(negedge clk);
                    i_rdy = 1'b0;
                    repeat (3) @(negedge clk);
                end
            end
        join
        chk("t3_drained", FW'(o_val), FW'(0));

        // T4: short frame.
        i_rdy = 1'b1;
        send_frame(5, 6, 1'b1);
        chk("t4_err", FW'(o_err), FW'(1));
        chk("t4_cnt", FW'(o_err_cnt), FW'(1));
        send_frame(70, R, 1'b1);
        chk("t4_word0", FW'(o_data[W-1:0]), FW'(70));
        idle(2);

        // T5: 13-sample frame is dropped whole.
        send_frame(90, 13, 1'b1);
        chk("t5_cnt", FW'(o_err_cnt), FW'(2));
        chk("t5_noval", FW'(o_val), FW'(0));
        send_frame(100, R, 1'b1);
        chk("t5_word11", FW'(o_data[11*W +: W]), FW'(111));
        idle(2);

        // T6: reset while one frame is held and another is partial.
        i_rdy = 1'b0;
        send_frame(10, R, 1'b1);
        send_frame(30, 7, 1'b0);
        do_reset();
        chk("t6_val", FW'(o_val), FW'(0));
        chk("t6_cnt", FW'(o_err_cnt), FW'(0));
        chk("t6_rdy", FW'(o_llr_rdy), FW'(1));
        i_rdy = 1'b1;
        send_frame(50, R, 1'b1);
        chk("t6_lat", FW'(o_val), FW'(1));
        chk("t6_word3", FW'(o_data[3*W +: W]), FW'(53));
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

endmodule
